// File: rtl/arm_mc_controller.sv
// Multicycle control FSM for the ARMv4-subset core: sequences the shared-memory datapath,
// holds NZCV and a registered condition-pass bit, and gates architectural writes by condition.
module arm_mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic         MemWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [2:0]   ALUControl,
  output logic         MovFlag
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t      state, state_next;
  logic [3:0]  flags;
  logic        condex, condexreg;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        unused_bits;
  logic [2:0]  alu_ctl;
  logic        alu_ok, alu_mov, alu_cv;
  logic        fw_nz, fw_cv;

  assign cond        = Instr[31:28];
  assign op          = Instr[27:26];
  assign funct       = Instr[25:20];
  assign rd          = Instr[15:12];
  assign unused_bits = ^Instr[19:16];

  function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: condcheck = z;
      4'b0001: condcheck = ~z;
      4'b0010: condcheck = cy;
      4'b0011: condcheck = ~cy;
      4'b0100: condcheck = n;
      4'b0101: condcheck = ~n;
      4'b0110: condcheck = v;
      4'b0111: condcheck = ~v;
      4'b1000: condcheck = cy & ~z;
      4'b1001: condcheck = ~cy | z;
      4'b1010: condcheck = (n == v);
      4'b1011: condcheck = (n != v);
      4'b1100: condcheck = ~z & (n == v);
      4'b1101: condcheck = z | (n != v);
      4'b1110: condcheck = 1'b1;
      default: condcheck = 1'b0;
    endcase
  endfunction

  assign condex = condcheck(cond, flags);

  // Data-processing decode; alu_ok=0 marks an unsupported funct whose writeback is dropped
  always_comb begin
    alu_ctl = 3'b000;
    alu_ok  = 1'b1;
    alu_mov = 1'b0;
    alu_cv  = 1'b0;
    case (funct[4:1])
      4'b0100: alu_cv = 1'b1;
      4'b0010: begin alu_ctl = 3'b001; alu_cv = 1'b1; end
      4'b0000: alu_ctl = 3'b010;
      4'b1100: alu_ctl = 3'b011;
      4'b1101: alu_mov = 1'b1;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      condexreg <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) condexreg <= condex;
      if (fw_nz) flags[3:2] <= ALUFlags[3:2];
      if (fw_cv) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_next = FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    MovFlag    = 1'b0;
    fw_nz      = 1'b0;
    fw_cv      = 1'b0;
    case (op)
      2'b01:   begin RegSrc = 2'b10; ImmSrc = 2'b01; end
      2'b10:   begin RegSrc = 2'b01; ImmSrc = 2'b10; end
      default: begin RegSrc = 2'b00; ImmSrc = 2'b00; end
    endcase
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = funct[5] ? EXECI : EXECR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condexreg;
        PCWrite   = condexreg & (rd == 4'hF);
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condexreg;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        MovFlag    = alu_mov;
        fw_nz      = condexreg & funct[0] & alu_ok & ~alu_mov;
        fw_cv      = condexreg & funct[0] & alu_cv;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite = condexreg & alu_ok;
        PCWrite  = condexreg & alu_ok & (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condexreg;
      end
      default: state_next = FETCH;
    endcase
    // Async reset parks the FSM in FETCH; keep its enables quiet until reset releases
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MovFlag  = 1'b0;
      fw_nz    = 1'b0;
      fw_cv    = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: per-instruction behavioural model (cycle index within each
// instruction, NZCV flags, condition table) compared against every DUT output each cycle.
module tb_arm_mc_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, MovFlag;
  logic [1:0]   RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]   ALUControl;

  always #5 clk = ~clk;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .MovFlag(MovFlag)
  );

  // Bit map: 17 PCW, 16 IRW, 15 RegW, 14 MemW, 13 AdrSrc, 12:11 RegSrc, 10 SrcA,
  // 9:8 SrcB, 7:6 ResultSrc, 5:4 ImmSrc, 3:1 ALUControl, 0 MovFlag
  logic [17:0] dut_vec;
  assign dut_vec = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, ALUControl, MovFlag};

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  mflags;
  logic        mpass;
  logic [17:0] obs [0:4];
  logic [31:0] rins;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cy;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cy & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? ~b : b;
  endfunction

  function automatic int latency(input logic [31:0] ins);
    case (ins[27:26])
      2'b01:   return ins[20] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [17:0] exp_vec(input int k, input logic [31:0] ins, input logic pass);
    logic [1:0] op, regsrc, srcb, res, imm;
    logic [5:0] fn;
    logic [2:0] alu;
    logic       r15, pcw, irw, rw, mw, adr, srca, mov, supp;
    op = ins[27:26]; fn = ins[25:20]; r15 = (ins[15:12] == 4'hF);
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; srca = 0; mov = 0;
    srcb = 0; res = 0; alu = 0;
    regsrc = (op == 2'b01) ? 2'b10 : (op == 2'b10) ? 2'b01 : 2'b00;
    imm    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    if (k == 0) begin
      pcw = 1; irw = 1; srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      srca = 1; srcb = 2'b10; res = 2'b10;
    end else begin
      case (op)
        2'b01: begin
          if (k == 2) srcb = 2'b01;
          else if (k == 3) begin adr = 1; mw = pass & ~fn[0]; end
          else begin res = 2'b01; rw = pass; pcw = pass & r15; end
        end
        2'b00: begin
          supp = 1;
          case (fn[4:1])
            4'b0100: alu = 3'd0;
            4'b0010: alu = 3'd1;
            4'b0000: alu = 3'd2;
            4'b1100: alu = 3'd3;
            4'b1101: mov = (k == 2);
            default: supp = 0;
          endcase
          if (k == 2) srcb = fn[5] ? 2'b01 : 2'b00;
          else begin alu = 0; rw = pass & supp; pcw = pass & supp & r15; end
        end
        2'b10: begin srcb = 2'b01; res = 2'b10; pcw = pass; end
        default: ;
      endcase
    end
    return {pcw, irw, rw, mw, adr, regsrc, srca, srcb, res, imm, alu, mov};
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int ncyc, input bit rnd, input logic [3:0] af);
    int n;
    n = latency(ins);
    if (ncyc < n) n = ncyc;
    for (int i = 0; i < 5; i++) obs[i] = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      Instr    = ins[31:12];
      ALUFlags = rnd ? 4'($urandom) : af;
      #1;
      obs[k] = dut_vec;
      if (k == 1) mpass = model_cond(ins[31:28], mflags);
      check($sformatf("ins %08h cyc%0d", ins, k), int'(dut_vec), int'(exp_vec(k, ins, mpass)));
      if (k == 2 && ins[27:26] == 2'b00 && mpass && ins[20]) begin
        case (ins[24:21])
          4'b0100, 4'b0010: mflags = ALUFlags;
          4'b0000, 4'b1100: mflags[3:2] = ALUFlags[3:2];
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mflags = 4'b0000; mpass = 1'b0;
    reset = 1'b1; Instr = '0; ALUFlags = 4'b0000;
    #3;
    check("reset outputs", int'(dut_vec),
          int'({4'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0}));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // ADD R2,R0,#5
    run_instr(32'hE2802005, 5, 1, 4'b0);
    check("add execi srcb", int'(obs[2][9:8]), 1);
    check("add execi aluctl", int'(obs[2][3:1]), 0);
    check("add aluwb regwrite", int'(obs[3][15]), 1);
    check("add execi regwrite", int'(obs[2][15]), 0);
    check("add fetch pcwrite", int'(obs[0][17]), 1);
    check("add aluwb pcwrite", int'(obs[3][17]), 0);

    // SUBS with Z, then BEQ taken; SUBS clear, then BEQ not taken but still 3 cycles
    run_instr(32'hE0520003, 5, 0, 4'b0100);
    run_instr(32'h0A000002, 5, 1, 4'b0);
    check("beq taken pcwrite", int'(obs[2][17]), 1);
    run_instr(32'hE0520003, 5, 0, 4'b0000);
    run_instr(32'h0A000002, 5, 1, 4'b0);
    check("beq not taken pcwrite", int'(obs[2][17]), 0);
    run_instr(32'hE2802005, 5, 1, 4'b0);
    check("fetch after beq irwrite", int'(obs[0][16]), 1);

    // LDR R1,[R0,#4]
    run_instr(32'hE5901004, 5, 1, 4'b0);
    check("ldr memrd adrsrc", int'(obs[3][13]), 1);
    check("ldr memwb regwrite", int'(obs[4][15]), 1);
    check("ldr memwb resultsrc", int'(obs[4][7:6]), 1);
    check("ldr memwrite any", int'(obs[0][14] | obs[1][14] | obs[2][14] | obs[3][14] | obs[4][14]), 0);

    // STR R1,[R0,#4]
    run_instr(32'hE5801004, 5, 1, 4'b0);
    check("str memwr memwrite", int'(obs[3][14]), 1);
    check("str memadr memwrite", int'(obs[2][14]), 0);
    check("str regwrite any", int'(obs[0][15] | obs[1][15] | obs[2][15] | obs[3][15]), 0);

    // Flags 0000, then ORRS with ALUFlags 1011 -> NZCV 1000
    run_instr(32'hE0520003, 5, 0, 4'b0000);
    run_instr(32'hE3900001, 5, 0, 4'b1011);
    run_instr(32'h4A000002, 5, 1, 4'b0);
    check("bmi after orrs", int'(obs[2][17]), 1);
    run_instr(32'h2A000002, 5, 1, 4'b0);
    check("bcs after orrs", int'(obs[2][17]), 0);
    run_instr(32'h6A000002, 5, 1, 4'b0);
    check("bvs after orrs", int'(obs[2][17]), 0);

    // MOV R15,R1
    run_instr(32'hE1A0F001, 5, 1, 4'b0);
    check("mov execr movflag", int'(obs[2][0]), 1);
    check("mov aluwb regwrite", int'(obs[3][15]), 1);
    check("mov aluwb pcwrite", int'(obs[3][17]), 1);

    // Set flags nonzero, then asynchronous reset in the MEMRD cycle of an LDR
    run_instr(32'hE0520003, 5, 0, 4'b0110);
    run_instr(32'hE5901004, 4, 1, 4'b0);
    #2 reset = 1'b1;
    #1;
    check("async reset in memrd", int'(dut_vec),
          int'({4'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b10, 2'b01, 3'b000, 1'b0}));
    @(posedge clk); #1;
    check("reset held", int'(dut_vec),
          int'({4'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b10, 2'b01, 3'b000, 1'b0}));
    mflags = 4'b0000;
    @(posedge clk);
    #2 reset = 1'b0;
    run_instr(32'hEC000000, 5, 1, 4'b0);
    check("op11 fetch irwrite", int'(obs[0][16]), 1);
    check("op11 decode enables", int'(obs[1][17:14]), 0);
    run_instr(32'h0A000002, 5, 1, 4'b0);
    check("beq after reset", int'(obs[2][17]), 0);
    run_instr(32'h1A000002, 5, 1, 4'b0);
    check("bne after reset", int'(obs[2][17]), 1);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      rins = $urandom;
      run_instr(rins, 5, 1, 4'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
